// File: rtl/image_mem_arbiter.sv
// Shares the single-port image RAM between the CPU IO window and the display scanner.
// Latency: grants and RAM controls are combinational; read data returns one cycle after the grant.
// Backpressure: requests are held until granted; display wins ties for up to MAX_DISP_RUN cycles.
module image_mem_arbiter #(
    parameter int ADDR_W       = 22,
    parameter int DATA_W       = 8,
    parameter int ORIG_BASE    = 120,
    parameter int IMG_SIZE     = 160000,
    parameter int MAX_DISP_RUN = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              disp_req,
    input  logic              disp_sel,
    input  logic [18:0]       disp_idx,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [18:0]       mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam logic [ADDR_W-1:0] BASE_A  = ADDR_W'(ORIG_BASE);
    localparam logic [ADDR_W:0]   SPAN    = (ADDR_W+1)'(2 * IMG_SIZE);
    localparam logic [18:0]       IMG_SZ  = 19'(IMG_SIZE);
    localparam logic [2:0]        RUN_MAX = 3'(MAX_DISP_RUN);

    localparam logic [1:0] TAG_NONE = 2'd0;
    localparam logic [1:0] TAG_CPU  = 2'd1;
    localparam logic [1:0] TAG_DISP = 2'd2;

    logic [2:0]        run_cnt;
    logic [1:0]        tag;
    logic              tag_zero;
    logic [DATA_W-1:0] cpu_hold;
    logic [DATA_W-1:0] disp_hold;
    logic [DATA_W-1:0] ret_dat;
    logic [ADDR_W:0]   cpu_off;
    logic              cpu_ok;
    logic              disp_ok;
    logic [18:0]       disp_addr;

    assign cpu_off   = {1'b0, cpu_addr} - {1'b0, BASE_A};
    assign cpu_ok    = (cpu_addr >= BASE_A) && (cpu_off < SPAN);
    assign disp_ok   = disp_idx < IMG_SZ;
    assign disp_addr = disp_idx + (disp_sel ? IMG_SZ : 19'd0);

    // Display keeps priority only until it has starved a waiting CPU for RUN_MAX cycles.
    always_comb begin
        cpu_gnt  = 1'b0;
        disp_gnt = 1'b0;
        if (rst_n) begin
            if (disp_req && !(cpu_req && run_cnt == RUN_MAX))
                disp_gnt = 1'b1;
            else if (cpu_req)
                cpu_gnt = 1'b1;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt && cpu_ok) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_off[18:0];
            mem_wdata = cpu_wdata;
        end else if (disp_gnt && disp_ok) begin
            mem_en    = 1'b1;
            mem_addr  = disp_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= 3'd0;
        end else if (!cpu_req || cpu_gnt) begin
            run_cnt <= 3'd0;
        end else if (disp_gnt && run_cnt < RUN_MAX) begin
            run_cnt <= run_cnt + 3'd1;
        end
    end

    // Out-of-range reads still complete, flagged to return zero instead of RAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag      <= TAG_NONE;
            tag_zero <= 1'b0;
            cpu_err  <= 1'b0;
        end else begin
            cpu_err <= cpu_gnt && !cpu_ok;
            if (cpu_gnt && !cpu_we) begin
                tag      <= TAG_CPU;
                tag_zero <= !cpu_ok;
            end else if (disp_gnt) begin
                tag      <= TAG_DISP;
                tag_zero <= !disp_ok;
            end else begin
                tag      <= TAG_NONE;
                tag_zero <= 1'b0;
            end
        end
    end

    assign ret_dat = tag_zero ? '0 : mem_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_hold  <= '0;
            disp_hold <= '0;
        end else begin
            if (tag == TAG_CPU)
                cpu_hold <= ret_dat;
            if (tag == TAG_DISP)
                disp_hold <= ret_dat;
        end
    end

    assign cpu_rvalid  = (tag == TAG_CPU);
    assign disp_rvalid = (tag == TAG_DISP);
    assign cpu_rdata   = cpu_rvalid  ? ret_dat : cpu_hold;
    assign disp_rdata  = disp_rvalid ? ret_dat : disp_hold;

endmodule

// File: tb/tb_image_mem_arbiter.sv
// Bench for image_mem_arbiter: RAM model plus image-level reference of arbitration and returns.
module tb_image_mem_arbiter;
    localparam int ADDR_W = 22;
    localparam int DATA_W = 8;
    localparam int BASE   = 120;
    localparam int IMG    = 160000;
    localparam int MAXR   = 4;
    localparam int IMG2   = 2 * IMG;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt, cpu_rvalid, cpu_err;
    logic [DATA_W-1:0] cpu_rdata;
    logic              disp_req, disp_sel;
    logic [18:0]       disp_idx;
    logic              disp_gnt, disp_rvalid;
    logic [DATA_W-1:0] disp_rdata;
    logic              mem_en, mem_we;
    logic [18:0]       mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    image_mem_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ORIG_BASE(BASE),
        .IMG_SIZE(IMG), .MAX_DISP_RUN(MAXR)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .disp_req(disp_req), .disp_sel(disp_sel), .disp_idx(disp_idx),
        .disp_gnt(disp_gnt), .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Physical RAM driven by the DUT.
    bit [7:0] ram [0:IMG2-1];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                if (int'(mem_addr) < IMG2) ram[mem_addr] <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    // Reference model state.
    bit [7:0] img [0:IMG2-1];
    int       streak;
    bit       ret_cpu, ret_disp, err_exp;
    bit [7:0] ret_cpu_val, ret_disp_val, cpu_hold_m, disp_hold_m;
    bit       last_cg, last_dg;
    int       total = 0;
    int       bad = 0;

    function automatic int cpu_index(input int addr);
        if (addr < BASE || addr >= BASE + IMG2) return -1;
        return addr - BASE;
    endfunction

    function automatic int disp_index(input int sel, input int idx);
        if (idx >= IMG) return -1;
        return idx + sel * IMG;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        streak = 0; ret_cpu = 0; ret_disp = 0; err_exp = 0;
        ret_cpu_val = 0; ret_disp_val = 0; cpu_hold_m = 0; disp_hold_m = 0;
    endtask

    task automatic set_cpu(input bit req, input bit we, input int addr, input int dat);
        cpu_req = req; cpu_we = we; cpu_addr = ADDR_W'(addr); cpu_wdata = 8'(dat);
    endtask

    task automatic set_disp(input bit req, input bit sel, input int idx);
        disp_req = req; disp_sel = sel; disp_idx = 19'(idx);
    endtask

    // One cycle: called at a negedge with inputs driven; compares, then advances the model.
    task automatic step(input bit rst_at_edge = 1'b0);
        int ci, di;
        bit eg_c, eg_d;
        if (!rst_n) model_reset();
        #1;
        ci   = cpu_index(int'(cpu_addr));
        di   = disp_index(int'(disp_sel), int'(disp_idx));
        eg_d = rst_n && disp_req && !(cpu_req && streak == MAXR);
        eg_c = rst_n && cpu_req && !eg_d;
        chk("cpu_gnt", cpu_gnt, eg_c);
        chk("disp_gnt", disp_gnt, eg_d);
        if (eg_c && ci >= 0) begin
            chk("mem_en", mem_en, 1);
            chk("mem_we", mem_we, cpu_we);
            chk("mem_addr", mem_addr, ci);
            if (cpu_we) chk("mem_wdata", mem_wdata, cpu_wdata);
        end else if (eg_d && di >= 0) begin
            chk("mem_en", mem_en, 1);
            chk("mem_we", mem_we, 0);
            chk("mem_addr", mem_addr, di);
        end else begin
            chk("mem_en", mem_en, 0);
            if (!eg_c && !eg_d) begin
                chk("idle_we", mem_we, 0);
                chk("idle_addr", mem_addr, 0);
                chk("idle_wdata", mem_wdata, 0);
            end
        end
        chk("cpu_rvalid", cpu_rvalid, ret_cpu);
        chk("cpu_rdata", cpu_rdata, ret_cpu ? ret_cpu_val : cpu_hold_m);
        chk("cpu_err", cpu_err, err_exp);
        chk("disp_rvalid", disp_rvalid, ret_disp);
        chk("disp_rdata", disp_rdata, ret_disp ? ret_disp_val : disp_hold_m);
        last_cg = eg_c;
        last_dg = eg_d;
        @(posedge clk);
        if (rst_at_edge) begin
            rst_n = 1'b0;
            model_reset();
        end else if (rst_n) begin
            if (ret_cpu)  cpu_hold_m  = ret_cpu_val;
            if (ret_disp) disp_hold_m = ret_disp_val;
            ret_cpu      = eg_c && !cpu_we;
            ret_cpu_val  = (ci >= 0) ? img[ci] : 8'd0;
            ret_disp     = eg_d;
            ret_disp_val = (di >= 0) ? img[di] : 8'd0;
            err_exp      = eg_c && ci < 0;
            if (eg_c && cpu_we && ci >= 0) img[ci] = cpu_wdata;
            if (!cpu_req || eg_c) streak = 0;
            else if (eg_d && streak < MAXR) streak++;
        end
        @(negedge clk);
    endtask

    function automatic int rand_cpu_addr();
        case ($urandom_range(0, 5))
            0:       return BASE + int'($urandom_range(0, 15));
            1:       return BASE + IMG - 8 + int'($urandom_range(0, 15));
            2:       return BASE + IMG2 - 8 + int'($urandom_range(0, 15));
            3:       return int'($urandom_range(0, 130));
            4:       return int'($urandom_range(0, 4194303));
            default: return BASE + int'($urandom_range(0, IMG2 - 1));
        endcase
    endfunction

    function automatic int rand_disp_idx();
        case ($urandom_range(0, 3))
            0:       return int'($urandom_range(0, 15));
            1:       return IMG - 8 + int'($urandom_range(0, 15));
            2:       return int'($urandom_range(0, 524287));
            default: return int'($urandom_range(0, IMG - 1));
        endcase
    endfunction

    initial begin
        bit [9:0] seq;
        rst_n = 1'b0;
        set_cpu(0, 0, 0, 0);
        set_disp(0, 0, 0);
        last_cg = 0; last_dg = 0;
        model_reset();
        @(negedge clk);

        // Reset with both requesting, then release.
        set_cpu(1, 0, BASE, 0);
        set_disp(1, 0, 5);
        #1;
        chk("rst_gnt", int'(cpu_gnt | disp_gnt), 0);
        chk("rst_mem_en", mem_en, 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("first_gnt_disp", disp_gnt, 1);
        step();
        set_disp(0, 0, 0);
        step();

        // CPU write then read back.
        set_cpu(1, 1, BASE, 8'h5A);
        #1;
        chk("wr_addr", mem_addr, 0);
        chk("wr_we", mem_we, 1);
        step();
        set_cpu(1, 0, BASE, 0);
        step();
        set_cpu(0, 0, 0, 0);
        chk("rd_vld", cpu_rvalid, 1);
        chk("rd_dat", cpu_rdata, 8'h5A);
        step();

        // Processed image seen through both address forms.
        set_cpu(1, 1, BASE + IMG, 8'hC3);
        #1;
        chk("alias_addr", mem_addr, IMG);
        step();
        set_cpu(0, 0, 0, 0);
        set_disp(1, 1, 0);
        step();
        set_disp(0, 0, 0);
        chk("alias_vld", disp_rvalid, 1);
        chk("alias_dat", disp_rdata, 8'hC3);
        step();

        // Display index past the image returns zero.
        set_disp(1, 0, IMG);
        step();
        set_disp(0, 0, 0);
        chk("door_vld", disp_rvalid, 1);
        chk("door_dat", disp_rdata, 0);
        step();

        // Contention: display capped at MAXR grants in a row.
        set_cpu(1, 0, BASE, 0);
        set_disp(1, 0, 3);
        for (int k = 0; k < 10; k++) begin
            step();
            seq[k] = last_cg;
            if (last_cg) set_cpu(1, 0, BASE + k, 0);
        end
        chk("contend_seq", int'(seq), int'(10'b1000010000));
        set_cpu(0, 0, 0, 0);
        set_disp(0, 0, 0);
        step();

        // CPU out-of-range reads.
        set_cpu(1, 0, 96, 0);
        #1;
        chk("oor_gnt", cpu_gnt, 1);
        chk("oor_en", mem_en, 0);
        step();
        set_cpu(1, 0, BASE + IMG2, 0);
        chk("oor_err", cpu_err, 1);
        chk("oor_vld", cpu_rvalid, 1);
        chk("oor_dat", cpu_rdata, 0);
        #1;
        chk("oor2_en", mem_en, 0);
        step();
        set_cpu(0, 0, 0, 0);
        chk("oor2_err", cpu_err, 1);
        chk("oor2_vld", cpu_rvalid, 1);
        chk("oor2_dat", cpu_rdata, 0);
        step();

        // Reset lands on the edge after a display read grant.
        set_disp(1, 1, 0);
        step();
        step(1'b1);
        set_disp(0, 0, 0);
        chk("rstrd_vld", disp_rvalid, 0);
        chk("rstrd_dat", disp_rdata, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("rstrd_vld2", disp_rvalid, 0);

        // Randomized traffic with two asynchronous resets.
        last_cg = 0; last_dg = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i == 1500 || i == 2700) rst_n = 1'b0;
            if (i == 1502 || i == 2702) rst_n = 1'b1;
            if (!cpu_req || last_cg) begin
                if ($urandom_range(0, 3) != 0)
                    set_cpu(1, 1'($urandom_range(0, 1)), rand_cpu_addr(), int'($urandom_range(0, 255)));
                else
                    cpu_req = 1'b0;
            end
            if (!disp_req || last_dg) begin
                if ($urandom_range(0, 3) != 0)
                    set_disp(1, 1'($urandom_range(0, 1)), rand_disp_idx());
                else
                    disp_req = 1'b0;
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/image_mem_arbiter.md
# image_mem_arbiter

Shares the single-port image RAM between the pipeline's memory-mapped IO path and the display scanner. The RAM holds the original image and the processed image back to back. The CPU reaches it through the byte-address window that the IO decoder flags as original or processed. The display reads pixels by index and image select. The block grants one requester per cycle and maps both address forms onto one physical RAM index. It returns read data with fixed latency and bounds display priority so that CPU stores always make progress.

## Interface
- ADDR_W, 22, CPU byte-address width
- DATA_W, 8, pixel width
- ORIG_BASE, 120, CPU address of original pixel 0
- IMG_SIZE, 160000, pixels per image; processed image starts at ORIG_BASE+IMG_SIZE
- MAX_DISP_RUN, 4, consecutive display grants allowed while CPU waits
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU access request; held until cpu_gnt
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU byte address
- cpu_wdata  in  DATA_W  write pixel
- cpu_gnt  out  1  access accepted this cycle (combinational)
- cpu_rvalid  out  1  read data valid pulse
- cpu_rdata  out  DATA_W  read pixel; held between pulses
- cpu_err  out  1  one-cycle pulse, granted address outside both images
- disp_req  in  1  display read request; held until disp_gnt
- disp_sel  in  1  0 = original image, 1 = processed image
- disp_idx  in  19  pixel index within the selected image
- disp_gnt  out  1  display read accepted (combinational)
- disp_rvalid  out  1  display data valid pulse
- disp_rdata  out  DATA_W  display pixel; held between pulses
- mem_en  out  1  RAM access enable (combinational)
- mem_we  out  1  RAM write enable
- mem_addr  out  19  RAM index, 0..2*IMG_SIZE-1
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0

## Operation
- Arbitration is per cycle, with at most one of cpu_gnt/disp_gnt high. With only one requester, that requester is granted.
- When both request, the display wins unless run_cnt == MAX_DISP_RUN. In that case the CPU wins.
- run_cnt (3 bits, saturating at MAX_DISP_RUN):
  - increments on a display grant while cpu_req is high;
  - clears on a CPU grant, or on any cycle where cpu_req is low.
- CPU mapping: off = cpu_addr − ORIG_BASE, computed unsigned in ADDR_W+1 bits.
  - Valid if cpu_addr ≥ ORIG_BASE and off < 2*IMG_SIZE; then mem_addr = off[18:0].
- Display mapping: mem_addr = disp_idx + (disp_sel ? IMG_SIZE : 0).
  - Valid if disp_idx < IMG_SIZE.
- Granted valid access: mem_en=1, mem_we=cpu_we for CPU or 0 for display, mem_wdata=cpu_wdata.
- Granted invalid access: it is still granted, with mem_en=0. A CPU invalid access pulses cpu_err in the cycle after the grant. Invalid reads return 0 with normal rvalid timing. Invalid writes are dropped.
- No grant: mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Read return tracker is a 1-deep registered tag (NONE/CPU_RD/DISP_RD, plus a zero flag for invalid). It is loaded each cycle from the current grant.

## Timing
- Grants are combinational from the requests and run_cnt. A requester samples its grant in the same cycle and may present the next request in the following cycle. This gives a throughput of one access per cycle.
- Read latency: a grant in cycle N produces rvalid in cycle N+1.
  - On a valid read, rdata = mem_rdata in cycle N+1.
  - On an invalid read, rdata = 0.
  - rdata is registered into the hold register at the end of cycle N+1, and the output mux exposes mem_rdata directly during cycle N+1.
- CPU writes produce no rvalid. A write is complete at the grant edge.
- Simultaneous requests at reset release: display first, unless MAX_DISP_RUN = 0, in which case the CPU is always preferred.
- Reset (any time, asynchronous):
  - run_cnt=0, tag=NONE, cpu_rvalid=0, disp_rvalid=0, cpu_rdata=0, disp_rdata=0, cpu_err=0;
  - grants and mem_en are forced to 0 while rst_n=0;
  - a read granted the cycle before reset produces no rvalid after release.

## Test plan
- Reset: drive rst_n=0 mid-stream with both requesting -> all outputs 0 and no grants. After release, the first grant goes to the display.
- CPU write then read: write cpu_addr=120, data 0x5A -> mem_addr=0, mem_we=1. Then read 120 -> cpu_rvalid one cycle later with cpu_rdata=0x5A.
- Aliasing: CPU write cpu_addr=160120, data 0xC3 -> mem_addr=160000. Display read with disp_sel=1, disp_idx=0 -> disp_rdata=0xC3 one cycle after disp_gnt.
- Contention: both request continuously with MAX_DISP_RUN=4 -> grant sequence D,D,D,D,C,D,D,D,D,C. Each CPU read returns on the following cycle.
- Out of range: CPU read at cpu_addr=96 and at 320120 -> cpu_gnt=1, mem_en=0, cpu_err pulses, cpu_rvalid with rdata 0. Display disp_idx=160000 -> disp_rvalid with 0.
- Reset mid-read: display read granted, rst_n low on the next edge -> disp_rvalid never asserts and disp_rdata=0.
